// File: rtl/sim_run_ctrl.sv
// Run-length controller: counts cycles up to a captured limit and emits one finish pulse.
// Optional heartbeat pulse is built only when SIM_RUN_CTRL_HEARTBEAT_EN is defined.
module sim_run_ctrl #(
    parameter int CNT_W     = 32,
    parameter int HB_PERIOD = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycle_limit,
    input  logic             pause,
    input  logic             abort,
    output logic             running,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             finish,
    output logic             aborted,
    output logic             hb
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] count_inc;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             finish_q, finish_d;
    logic             aborted_q, aborted_d;
    logic             incr;
    logic             hb_clr;

    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        aborted_d = aborted_q;
        finish_d  = 1'b0;
        incr      = 1'b0;
        hb_clr    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    limit_d   = cycle_limit;
                    count_d   = '0;
                    aborted_d = 1'b0;
                    hb_clr    = 1'b1;
                    if (cycle_limit == '0) begin
                        state_d  = S_DONE;
                        // A zero-length restart right after a finish must not stretch the pulse
                        finish_d = ~finish_q;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Reaching the limit outranks abort; abort outranks pause
                if (!pause && (count_inc == limit_q)) begin
                    count_d   = count_inc;
                    incr      = 1'b1;
                    state_d   = S_DONE;
                    finish_d  = 1'b1;
                    aborted_d = 1'b0;
                end else if (abort) begin
                    state_d   = S_DONE;
                    finish_d  = 1'b1;
                    aborted_d = 1'b1;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    count_d = count_inc;
                    incr    = 1'b1;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d   = S_DONE;
                    finish_d  = 1'b1;
                    aborted_d = 1'b1;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        running_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            finish_q  <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            running_q <= running_d;
            done_q    <= done_d;
            finish_q  <= finish_d;
            aborted_q <= aborted_d;
        end
    end

    assign running = running_q;
    assign count   = count_q;
    assign done    = done_q;
    assign finish  = finish_q;
    assign aborted = aborted_q;

`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_PERIOD - 1);

    logic [CNT_W-1:0] hb_cnt_q, hb_cnt_d;
    logic             hb_q, hb_d;

    // Modulo counter advances only on real count increments, so it freezes during pause
    always_comb begin
        hb_cnt_d = hb_cnt_q;
        hb_d     = 1'b0;
        if (hb_clr) begin
            hb_cnt_d = '0;
        end else if (incr) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d = '0;
                hb_d     = 1'b1;
            end else begin
                hb_cnt_d = hb_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    assign hb = hb_q;
`else
    logic unused_hb_events;
    assign unused_hb_events = incr ^ hb_clr;
    assign hb               = 1'b0;
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: vector table plus hand-written abort, reset and max-limit sequences.
module tb_sim_run_ctrl;

    localparam int CNT_W = 8;
`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
    localparam bit HB_EN = 1'b1;
`else
    localparam bit HB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cycle_limit;
    logic             pause;
    logic             abort;
    logic             running;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             finish;
    logic             aborted;
    logic             hb;

    int checks   = 0;
    int failures = 0;

    sim_run_ctrl #(.CNT_W(CNT_W), .HB_PERIOD(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cycle_limit(cycle_limit),
        .pause      (pause),
        .abort      (abort),
        .running    (running),
        .count      (count),
        .done       (done),
        .finish     (finish),
        .aborted    (aborted),
        .hb         (hb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             start;
        logic [CNT_W-1:0] lim;
        logic             pause;
        logic             abort;
        logic             run;
        logic [CNT_W-1:0] cnt;
        logic             done;
        logic             fin;
        logic             ab;
        logic             hb;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input int lim, input logic p, input logic a,
                       input logic r, input int c, input logic d, input logic f,
                       input logic ab, input logic h);
        vec_t v;
        v.start = s; v.lim = CNT_W'(lim); v.pause = p; v.abort = a;
        v.run = r; v.cnt = CNT_W'(c); v.done = d; v.fin = f; v.ab = ab; v.hb = h;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic r, input int c, input logic d,
                             input logic f, input logic ab, input logic h);
        check({tag, ".running"}, int'(running), int'(r));
        check({tag, ".count"},   int'(count),   c);
        check({tag, ".done"},    int'(done),    int'(d));
        check({tag, ".finish"},  int'(finish),  int'(f));
        check({tag, ".aborted"}, int'(aborted), int'(ab));
        check({tag, ".hb"},      int'(hb),      int'(h && HB_EN));
    endtask

    task automatic drive(input logic s, input int lim, input logic p, input logic a);
        start = s; cycle_limit = CNT_W'(lim); pause = p; abort = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int fin_seen;
        drive(0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        //   st lim p a | run cnt done fin ab hb
        add(1,  5, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 2, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 3, 0, 0, 0, 1);
        add(0,  0, 0, 0,  1, 4, 0, 0, 0, 0);
        add(0,  0, 0, 0,  0, 5, 1, 1, 0, 0);
        add(0,  0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(1,  0, 0, 0,  0, 0, 1, 1, 0, 0);
        add(1,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        add(1, 10, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 2, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 3, 0, 0, 0, 1);
        add(0,  0, 0, 0,  1, 4, 0, 0, 0, 0);
        add(0,  0, 1, 0,  1, 4, 0, 0, 0, 0);
        add(0,  0, 1, 0,  1, 4, 0, 0, 0, 0);
        add(0,  0, 1, 0,  1, 4, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 4, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 5, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 6, 0, 0, 0, 1);
        add(0,  0, 0, 0,  1, 7, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 8, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 9, 0, 0, 0, 1);
        add(0,  0, 0, 0,  0, 10, 1, 1, 0, 0);
        add(1,  4, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 2, 0, 0, 0, 0);
        add(0,  0, 0, 1,  0, 2, 1, 1, 1, 0);
        add(0,  0, 0, 0,  0, 2, 1, 0, 1, 0);
        add(1,  2, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0,  0, 0, 1,  0, 2, 1, 1, 0, 0);
        add(1,  3, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0,  0, 1, 1,  0, 0, 1, 1, 1, 0);
        add(1,  3, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0,  0, 1, 0,  1, 0, 0, 0, 0, 0);
        add(1,  7, 1, 0,  1, 0, 0, 0, 0, 0);
        add(0,  0, 1, 1,  0, 0, 1, 1, 1, 0);
        add(0,  0, 0, 0,  0, 0, 1, 0, 1, 0);
        add(1,  9, 0, 0,  1, 0, 0, 0, 0, 0);
        add(1,  2, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0,  0, 0, 0,  1, 2, 0, 0, 0, 0);
        add(0,  0, 0, 1,  0, 2, 1, 1, 1, 0);

        foreach (vq[i]) begin
            drive(vq[i].start, int'(vq[i].lim), vq[i].pause, vq[i].abort);
            step();
            $display("vec %0d: start=%0b lim=%0d pause=%0b abort=%0b -> run=%0b cnt=%0d done=%0b fin=%0b ab=%0b hb=%0b",
                     i, vq[i].start, vq[i].lim, vq[i].pause, vq[i].abort,
                     running, count, done, finish, aborted, hb);
            check_all($sformatf("v%0d", i), vq[i].run, int'(vq[i].cnt), vq[i].done,
                      vq[i].fin, vq[i].ab, vq[i].hb);
        end

        // Long run aborted at count 37, then a clean restart clears aborted
        drive(1, 100, 0, 0);
        step();
        drive(0, 0, 0, 0);
        n = 0;
        while (count != CNT_W'(37) && n < 200) begin
            step();
            n++;
        end
        check("abort37.reach", int'(count), 37);
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
        $display("abort37: done=%0b aborted=%0b count=%0d finish=%0b", done, aborted, count, finish);
        check_all("abort37", 0, 37, 1, 1, 1, 0);
        step();
        check("abort37.single_finish", int'(finish), 0);
        drive(1, 2, 0, 0);
        step();
        drive(0, 0, 0, 0);
        check("restart2.aborted", int'(aborted), 0);
        step();
        step();
        $display("restart2: done=%0b finish=%0b count=%0d", done, finish, count);
        check("restart2.finish", int'(finish), 1);
        check("restart2.count", int'(count), 2);

        // Asynchronous reset between edges mid-run
        drive(1, 8, 0, 0);
        step();
        drive(0, 0, 0, 0);
        repeat (4) step();
        check("rstmid.count_before", int'(count), 4);
        #2 rst = 1'b1;
        #1;
        $display("rstmid: run=%0b cnt=%0d done=%0b fin=%0b", running, count, done, finish);
        check_all("rstmid", 0, 0, 0, 0, 0, 0);
        fin_seen = 0;
        repeat (3) begin
            step();
            if (finish) fin_seen++;
        end
        rst = 1'b0;
        repeat (8) begin
            step();
            if (finish) fin_seen++;
        end
        check("rstmid.no_finish", fin_seen, 0);
        drive(1, 2, 0, 0);
        step();
        drive(0, 0, 0, 0);
        check("rstmid.restart_run", int'(running), 1);
        step();
        step();
        check("rstmid.restart_finish", int'(finish), 1);

        // Maximum limit runs to completion without wrapping
        drive(1, 255, 0, 0);
        step();
        drive(0, 0, 0, 0);
        n = 0;
        while (!finish && n < 400) begin
            step();
            n++;
        end
        $display("maxlim: edges=%0d count=%0d finish=%0b", n, count, finish);
        check("maxlim.edges", n, 255);
        check("maxlim.count", int'(count), 255);
        check("maxlim.aborted", int'(aborted), 0);
        step();
        check("maxlim.finish_once", int'(finish), 0);
        check("maxlim.count_held", int'(count), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
